// File: rtl/mem_stage.sv
// Load/store stage: one outstanding data-memory access, load alignment/extension, store lane masks.
// Optional misaligned-access trap enabled with `define MEM_STAGE_MISALIGN_CHECK_EN.
module mem_stage #(
  parameter int XLEN           = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [XLEN-1:0]           ex_alu_res,
  input  logic [XLEN-1:0]           ex_store_data,
  input  logic [3:0]                ex_mem_op,
  input  logic                      ex_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_waddr,
  input  logic                      ex_ebreak,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [XLEN-1:0]           mem_req_addr,
  output logic                      mem_req_wen,
  output logic [XLEN-1:0]           mem_req_wdata,
  output logic [7:0]                mem_req_wmask,
  input  logic                      mem_rsp_valid,
  input  logic [XLEN-1:0]           mem_rsp_rdata,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic                      wb_reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_waddr,
  output logic [XLEN-1:0]           wb_wdata,
  output logic                      wb_ebreak,
  output logic                      misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LD  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_LHU = 4'd6;
  localparam logic [3:0] OP_LWU = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_SD  = 4'd11;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LWU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SD);
  endfunction

  // Access size as log2(bytes)
  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 2'd0;
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      OP_LW, OP_LWU, OP_SW: return 2'd2;
      default:              return 2'd3;
    endcase
  endfunction

  state_t                    state, state_next;
  logic [3:0]                op_q;
  logic [XLEN-1:0]           addr_q;
  logic [XLEN-1:0]           sdata_q;
  logic [REG_ADDR_WIDTH-1:0] waddr_q;
  logic                      wen_q;
  logic                      ebreak_q;

  logic                      out_free;
  logic                      ex_fire;
  logic                      ex_is_mem;
  logic                      misaligned;
  logic                      bypass;
  logic                      store_q;
  logic [5:0]                shamt;
  logic [7:0]                base_mask;
  logic [XLEN-1:0]           lane;
  logic [XLEN-1:0]           load_data;

  assign out_free  = !wb_valid || wb_ready;
  assign ex_ready  = (state == IDLE) && out_free;
  assign ex_fire   = ex_valid && ex_ready;
  assign ex_is_mem = op_is_load(ex_mem_op) || op_is_store(ex_mem_op);

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (ex_is_mem) begin
      case (op_size(ex_mem_op))
        2'd1:    misaligned = ex_alu_res[0];
        2'd2:    misaligned = |ex_alu_res[1:0];
        2'd3:    misaligned = |ex_alu_res[2:0];
        default: misaligned = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_err <= 1'b0;
    else        misalign_err <= ex_fire && misaligned;
  end
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Non-memory ops and trapped misaligned accesses skip the bus entirely
  assign bypass = ex_fire && (!ex_is_mem || misaligned);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (ex_fire && ex_is_mem && !misaligned) state_next = REQ;
      REQ:     if (mem_req_ready) state_next = RSP;
      RSP:     if (mem_rsp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign store_q = op_is_store(op_q);
  assign shamt   = {addr_q[2:0], 3'b000};

  always_comb begin
    base_mask = 8'h00;
    case (op_size(op_q))
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  // Request fields come straight from the latched op, so they stay stable through a stall
  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
  assign mem_req_wen   = store_q;
  assign mem_req_wdata = store_q ? (sdata_q << shamt) : '0;
  assign mem_req_wmask = store_q ? (base_mask << addr_q[2:0]) : 8'h00;

  assign lane = mem_rsp_rdata >> shamt;

  always_comb begin
    load_data = lane;
    case (op_q)
      OP_LB:   load_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      OP_LH:   load_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      OP_LW:   load_data = {{(XLEN-32){lane[31]}}, lane[31:0]};
      OP_LBU:  load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      OP_LHU:  load_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      OP_LWU:  load_data = {{(XLEN-32){1'b0}}, lane[31:0]};
      OP_LD:   load_data = lane;
      default: load_data = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= 4'd0;
      addr_q       <= '0;
      sdata_q      <= '0;
      waddr_q      <= '0;
      wen_q        <= 1'b0;
      ebreak_q     <= 1'b0;
      wb_valid     <= 1'b0;
      wb_reg_wen   <= 1'b0;
      wb_reg_waddr <= '0;
      wb_wdata     <= '0;
      wb_ebreak    <= 1'b0;
    end else begin
      if (wb_valid && wb_ready) wb_valid <= 1'b0;
      if (bypass) begin
        wb_valid     <= 1'b1;
        wb_reg_wen   <= ex_reg_wen && !ex_is_mem && (ex_reg_waddr != '0);
        wb_reg_waddr <= ex_reg_waddr;
        wb_wdata     <= ex_alu_res;
        wb_ebreak    <= ex_ebreak;
      end else if (ex_fire) begin
        op_q     <= ex_mem_op;
        addr_q   <= ex_alu_res;
        sdata_q  <= ex_store_data;
        waddr_q  <= ex_reg_waddr;
        wen_q    <= ex_reg_wen;
        ebreak_q <= ex_ebreak;
      end else if (state == RSP && mem_rsp_valid) begin
        // Output register is always empty here: it had to be free when the op was accepted
        wb_valid     <= 1'b1;
        wb_reg_wen   <= wen_q && !store_q && (waddr_q != '0);
        wb_reg_waddr <= waddr_q;
        wb_wdata     <= store_q ? '0 : load_data;
        wb_ebreak    <= ebreak_q;
      end
    end
  end

endmodule
